// File: rtl/dmem_selfcheck.sv
// rtl/dmem_selfcheck.sv - word data memory with a hardware self-check FSM over the CPU store stream
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (trap misaligned stores while running)
module dmem_selfcheck #(
    parameter int          ADDR_W       = 6,
    parameter logic [31:0] PASS_ADDR    = 32'd84,
    parameter logic [31:0] PASS_DATA    = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR = 32'd80,
    parameter int          TIMEOUT      = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  fail_code,
    output logic [15:0] store_cnt
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_t;

    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [1:0]        code_next;
    logic [31:0]       timer;
    logic [31:0]       ram [0:2**ADDR_W-1];
    logic              we;
    logic [ADDR_W-1:0] widx;
    logic              is_pass_adr;
    logic              is_scratch_adr;
    logic              misaligned;

    // An X strobe must never look like a store, to the RAM or to the FSM.
    assign we       = (memwrite === 1'b1);
    assign widx     = dataadr[ADDR_W+1:2];
    assign readdata = ram[widx];

    // Word compare: the byte-lane bits never select a different target word.
    assign is_pass_adr    = (dataadr[31:2] == PASS_ADDR[31:2]);
    assign is_scratch_adr = (dataadr[31:2] == SCRATCH_ADDR[31:2]);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = (dataadr[1:0] != 2'b00);
`else
    logic unused_low_bits;
    assign misaligned      = 1'b0;
    assign unused_low_bits = ^dataadr[1:0];
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            ram[widx] <= writedata;
        end
    end

    always_comb begin
        state_next = state;
        code_next  = fail_code;
        if (state == RUN) begin
            if (we && misaligned) begin
                state_next = FAIL;
                code_next  = 2'd3;
            end else if (we && is_pass_adr && (writedata == PASS_DATA)) begin
                state_next = PASS;
            end else if (we && !is_scratch_adr) begin
                state_next = FAIL;
                code_next  = 2'd1;
            end else if (timer == TIMER_LAST) begin
                state_next = FAIL;
                code_next  = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            fail_code <= 2'd0;
            store_cnt <= 16'd0;
            timer     <= 32'd0;
        end else begin
            state     <= state_next;
            fail_code <= code_next;
            if (state == RUN) begin
                timer <= timer + 32'd1;
            end
            if (we && (store_cnt != 16'hFFFF)) begin
                store_cnt <= store_cnt + 16'd1;
            end
        end
    end

    assign pass = (state == PASS);
    assign fail = (state == FAIL);
    assign done = pass | fail;

endmodule

// File: tb/tb_dmem_selfcheck.sv
// tb/tb_dmem_selfcheck.sv - vector table, corner sequences and randomized model comparison for dmem_selfcheck
module tb_dmem_selfcheck;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        done, pass, fail;
    logic [1:0]  fail_code;
    logic [15:0] store_cnt;

    always #5 clk = ~clk;

    dmem_selfcheck #(
        .ADDR_W(6), .PASS_ADDR(32'd84), .PASS_DATA(32'd7),
        .SCRATCH_ADDR(32'd80), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .readdata(readdata), .done(done), .pass(pass),
        .fail(fail), .fail_code(fail_code), .store_cnt(store_cnt)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: verdict as 0 running / 1 pass / 2 fail, cycles counted since reset.
    logic [31:0] m_mem [64];
    bit          m_vld [64];
    int          m_state, m_code, m_cnt, m_edges;

    function automatic void model_edge(bit r, bit mw, logic [31:0] a, logic [31:0] d);
        if (mw) begin
            m_mem[(a / 4) % 64] = d;
            m_vld[(a / 4) % 64] = 1'b1;
        end
        if (r) begin
            m_state = 0; m_code = 0; m_cnt = 0; m_edges = 0;
            return;
        end
        if (mw && m_cnt < 65535) m_cnt++;
        if (m_state != 0) return;
        m_edges++;
        if (mw) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            if (a % 4 != 0) begin m_state = 2; m_code = 3; return; end
`endif
            if (a / 4 == 21 && d == 7) begin m_state = 1; return; end
            if (a / 4 != 20) begin m_state = 2; m_code = 1; return; end
        end
        if (m_edges == TO) begin m_state = 2; m_code = 2; end
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(bit r, logic mw, logic [31:0] a, logic [31:0] d);
        rst = r; memwrite = mw; dataadr = a; writedata = d;
        @(posedge clk);
        model_edge(r, mw === 1'b1, a, d);
        #1;
        rst = 1'b0; memwrite = 1'b0;
    endtask

    task automatic chk_model(string tag);
        chk({tag, " pass"}, 32'(pass), 32'(m_state == 1));
        chk({tag, " fail"}, 32'(fail), 32'(m_state == 2));
        chk({tag, " done"}, 32'(done), 32'(m_state != 0));
        chk({tag, " fail_code"}, 32'(fail_code), 32'(m_code));
        chk({tag, " store_cnt"}, 32'(store_cnt), 32'(m_cnt));
    endtask

    task automatic chk_outs(string tag, bit p, bit f, logic [1:0] c, logic [15:0] n);
        chk({tag, " pass"}, 32'(pass), 32'(p));
        chk({tag, " fail"}, 32'(fail), 32'(f));
        chk({tag, " done"}, 32'(done), 32'(p | f));
        chk({tag, " fail_code"}, 32'(fail_code), 32'(c));
        chk({tag, " store_cnt"}, 32'(store_cnt), 32'(n));
    endtask

    task automatic chk_load(string tag, logic [31:0] a, logic [31:0] exp);
        dataadr = a;
        #1;
        chk({tag, " readdata"}, readdata, exp);
    endtask

    typedef struct {
        logic [31:0] a1, d1, a2, d2;
        logic        p, f;
        logic [1:0]  code;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [31:0] a, d;
        logic        mw;
        int          sel;

        tbl[0] = '{32'd80, 32'd5, 32'd84, 32'd7, 1'b1, 1'b0, 2'd0, 16'd2};
        tbl[1] = '{32'd80, 32'd1, 32'd88, 32'd3, 1'b0, 1'b1, 2'd1, 16'd2};
        tbl[2] = '{32'd84, 32'd6, 32'd80, 32'd0, 1'b0, 1'b1, 2'd1, 16'd2};
        tbl[3] = '{32'd80, 32'd2, 32'd80, 32'd3, 1'b0, 1'b0, 2'd0, 16'd2};
`ifdef DMEM_MISALIGN_TRAP_EN
        tbl[4] = '{32'd85, 32'd7, 32'd80, 32'd4, 1'b0, 1'b1, 2'd3, 16'd2};
`else
        tbl[4] = '{32'd85, 32'd7, 32'd80, 32'd4, 1'b1, 1'b0, 2'd0, 16'd2};
`endif
        tbl[5] = '{32'd0, 32'd7, 32'd84, 32'd7, 1'b0, 1'b1, 2'd1, 16'd2};

        step(1'b1, 1'b0, 32'd0, 32'd0);
        chk_outs("reset", 1'b0, 1'b0, 2'd0, 16'd0);

        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'd0, 32'd0);
            step(1'b0, 1'b1, tbl[i].a1, tbl[i].d1);
            step(1'b0, 1'b1, tbl[i].a2, tbl[i].d2);
            chk_outs($sformatf("vec%0d", i), tbl[i].p, tbl[i].f, tbl[i].code, tbl[i].cnt);
            chk_load($sformatf("vec%0d", i), tbl[i].a2, tbl[i].d2);
        end

        // Store before pass word lands in RAM; terminal FAIL ignores a later pass store.
        step(1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 32'd80, 32'd1);
        step(1'b0, 1'b1, 32'd88, 32'd3);
        step(1'b0, 1'b1, 32'd84, 32'd7);
        chk_outs("terminal_fail", 1'b0, 1'b1, 2'd1, 16'd3);
        chk_load("terminal_fail", 32'd84, 32'd7);

        step(1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 32'd84, 32'd6);
        chk_outs("wrong_data", 1'b0, 1'b1, 2'd1, 16'd1);
        chk_load("wrong_data", 32'd84, 32'd6);

        // Timeout lands exactly on the 16th edge after reset release.
        step(1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
        chk("pre_timeout done", 32'(done), 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0);
        chk_outs("timeout", 1'b0, 1'b1, 2'd2, 16'd0);

        step(1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 32'd84, 32'd7);
        chk_outs("pass_at_timeout", 1'b1, 1'b0, 2'd0, 16'd1);

        // Reset beats a simultaneous store verdict but the store still commits.
        step(1'b1, 1'b1, 32'd80, 32'd9);
        chk_outs("rst_with_store", 1'b0, 1'b0, 2'd0, 16'd0);
        chk_load("rst_with_store", 32'd80, 32'd9);
        step(1'b0, 1'b1, 32'd84, 32'd7);
        chk_outs("rerun_after_rst", 1'b1, 1'b0, 2'd0, 16'd1);

        step(1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 32'd80, 32'h1234);
        step(1'b0, 1'bx, 32'd80, 32'hDEAD);
        chk_outs("x_strobe", 1'b0, 1'b0, 2'd0, 16'd1);
        chk_load("x_strobe", 32'd80, 32'h1234);

        // Randomized runs against the model.
        for (int r = 0; r < 30; r++) begin
            step(1'b1, 1'b0, 32'd0, 32'd0);
            chk_model($sformatf("rand%0d reset", r));
            for (int c = 0; c < 24; c++) begin
                mw  = ($urandom_range(0, 2) != 0);
                sel = $urandom_range(0, 7);
                case (sel)
                    0, 1, 2: a = 32'd80;
                    3:       a = 32'd84;
                    4:       a = 32'd85;
                    5:       a = 32'd88;
                    6:       a = 32'd82;
                    default: a = $urandom_range(0, 255);
                endcase
                d = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
                step(1'b0, mw, a, d);
                chk_model($sformatf("rand%0d.%0d", r, c));
                a = $urandom_range(0, 255);
                if (m_vld[(a / 4) % 64]) chk_load($sformatf("rand%0d.%0d", r, c), a, m_mem[(a / 4) % 64]);
            end
        end

        // store_cnt saturates and keeps counting after FAIL.
        step(1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 65534; i++) step(1'b0, 1'b1, 32'd80, 32'(i));
        chk_outs("cnt_fffe", 1'b0, 1'b1, 2'd2, 16'hFFFE);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'd80, 32'(i));
        chk_outs("cnt_sat", 1'b0, 1'b1, 2'd2, 16'hFFFF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
